mem_arbiter: RTL and testbench

- Shares one single-ported unified memory between the pipeline's instruction-fetch port and its data (load/store) port.
- Grants one requester at a time and registers the request onto the memory bus. Waits for a variable-latency memory acknowledge, then returns read data with a one-cycle valid pulse.
- Drives the fetch and memory-stage stall signals consumed by the hazard logic.
- A watchdog releases the bus if memory never acknowledges.

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter_wdog.sv | 32 +++
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/mem_arbiter_wdog.sv
// Bus watchdog: down-counter loaded at each grant, expires after TIMEOUT busy cycles.
module mem_arbiter_wdog
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Terminal count reached in the TIMEOUT-th busy cycle.
  assign expire = en && (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data access onto one single-ported memory.
// Optional round-robin tie-break when MEM_ARBITER_RR_EN is defined.
//
// state  | meaning
// IDLE   | bus free; sample requests and grant one (also the valid/bubble cycle)
// BUSY_I | fetch on the bus, waiting for mem_ack or watchdog expiry
// BUSY_D | load/store on the bus, waiting for mem_ack or watchdog expiry
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall_f,
  output logic          stall_m,
  output logic          err
);

  state_e        state, state_nxt;
  logic          mem_req_nxt, mem_we_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_wdata_nxt, i_rdata_nxt, d_rdata_nxt;
  logic          i_valid_nxt, d_valid_nxt, err_nxt;
  logic          grant_i, grant_d, wd_load, wd_expire, busy;

  // A request completing this cycle is masked so it is not granted twice.
  assign stall_f = i_req & ~i_valid;
  assign stall_m = d_req & ~d_valid;
  assign busy    = (state != IDLE);
  assign wd_load = grant_i | grant_d;

`ifdef MEM_ARBITER_RR_EN
  owner_e last_own;

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_own <= OWN_I;
    end else if (grant_d) begin
      last_own <= OWN_D;
    end else if (grant_i) begin
      last_own <= OWN_I;
    end
  end

  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
      if (stall_m && stall_f) begin
        grant_d = (last_own == OWN_I);
        grant_i = (last_own == OWN_D);
      end else begin
        grant_d = stall_m;
        grant_i = stall_f;
      end
    end
  end
`else
  assign grant_d = (state == IDLE) && stall_m;
  assign grant_i = (state == IDLE) && stall_f && !stall_m;
`endif

  mem_arbiter_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .load   (wd_load),
    .en     (busy),
    .expire (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_valid   <= 1'b0;
      d_valid   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      i_rdata   <= i_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      i_valid   <= i_valid_nxt;
      d_valid   <= d_valid_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    i_rdata_nxt   = i_rdata;
    d_rdata_nxt   = d_rdata;
    i_valid_nxt   = 1'b0;
    d_valid_nxt   = 1'b0;
    err_nxt       = err;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt     = BUSY_D;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = d_we;
          mem_addr_nxt  = d_addr;
          mem_wdata_nxt = d_wdata;
        end else if (grant_i) begin
          state_nxt    = BUSY_I;
          mem_req_nxt  = 1'b1;
          mem_we_nxt   = 1'b0;
          mem_addr_nxt = i_addr;
        end
      end
      BUSY_I: begin
        // mem_ack wins over a simultaneous watchdog expiry.
        if (mem_ack) begin
          i_rdata_nxt = mem_rdata;
          i_valid_nxt = 1'b1;
          mem_req_nxt = 1'b0;
          state_nxt   = IDLE;
        end else if (wd_expire) begin
          err_nxt     = 1'b1;
          i_valid_nxt = 1'b1;
          mem_req_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          if (!mem_we) begin
            d_rdata_nxt = mem_rdata;
          end
          d_valid_nxt = 1'b1;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          state_nxt   = IDLE;
        end else if (wd_expire) begin
          err_nxt     = 1'b1;
          d_valid_nxt = 1'b1;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          state_nxt   = IDLE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        mem_req_nxt = 1'b0;
        mem_we_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus random traffic against a memory model.
module tb_mem_arbiter;

  localparam int TMO   = 4;
  localparam int NEVER = 99;
`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, mem_ack;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_valid, d_valid, mem_req, mem_we, stall_f, stall_m, err;

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_f(stall_f), .stall_m(stall_m), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        tmo;
  } exp_t;

  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        q_i[$], q_d[$];
  int          lat_i, lat_d;
  bit          pend_i, pend_d, gnt_i, gnt_d, snap_i, snap_d;
  bit          last_d;
  bit          err_exp;
  bit          stray_en;
  logic [31:0] last_i_rd, last_d_rd;
  logic [31:0] ref_st[int];
  logic [31:0] mem_st[int];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0113;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_st.exists(int'(a))) return ref_st[int'(a)];
    return mem_init(a);
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_st.exists(int'(a))) return mem_st[int'(a)];
    return mem_init(a);
  endfunction

  // Expected result is fixed at issue time: a timed-out access leaves rdata untouched.
  task automatic issue_i(input logic [31:0] a, input int lat);
    exp_t e;
    i_addr = a; i_req = 1'b1; lat_i = lat; pend_i = 1'b1; gnt_i = 1'b0;
    e.tmo = (lat >= TMO);
    if (e.tmo) e.rdata = last_i_rd;
    else begin e.rdata = ref_read(a); last_i_rd = e.rdata; end
    q_i.push_back(e);
  endtask

  task automatic issue_d(input logic we, input logic [31:0] a, input logic [31:0] wd, input int lat);
    exp_t e;
    d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
    lat_d = lat; pend_d = 1'b1; gnt_d = 1'b0;
    e.tmo = (lat >= TMO);
    e.rdata = last_d_rd;
    if (!e.tmo) begin
      if (we) ref_st[int'(a)] = wd;
      else begin e.rdata = ref_read(a); last_d_rd = e.rdata; end
    end
    q_d.push_back(e);
  endtask

  task automatic wait_i(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!i_valid && n < 40);
    if (!i_valid) fail_now("i_valid_never_arrived");
    else begin #1; chk("stall_f_in_valid_cycle", stall_f, 0); end
    i_req = 1'b0; pend_i = 1'b0; gnt_i = 1'b0;
  endtask

  task automatic wait_d(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!d_valid && n < 40);
    if (!d_valid) fail_now("d_valid_never_arrived");
    else begin #1; chk("stall_m_in_valid_cycle", stall_m, 0); end
    d_req = 1'b0; pend_d = 1'b0; gnt_d = 1'b0;
  endtask

  function automatic int pick_lat();
    if ($urandom_range(0, 9) == 0) return NEVER;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic drive_i(input int cnt);
    int c;
    for (int k = 0; k < cnt; k++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      issue_i(32'($urandom_range(0, 63)) << 2, pick_lat());
      wait_i(c);
    end
  endtask

  task automatic drive_d(input int cnt);
    int c;
    for (int k = 0; k < cnt; k++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      issue_d(1'($urandom_range(0, 1)), 32'h100 + (32'($urandom_range(0, 63)) << 2),
              $urandom, pick_lat());
      wait_d(c);
    end
  endtask

  // Requests still waiting for a grant, as seen at each sampling edge.
  always @(posedge clk) begin
    snap_i <= pend_i && !gnt_i;
    snap_d <= pend_d && !gnt_d;
  end

  // Memory model: checks each bus transaction against the arbitration rules and acks it.
  initial begin
    bit          act, port_d;
    int          bcnt, lat;
    logic [31:0] a0, wd0;
    logic        we0;
    mem_ack = 1'b0; mem_rdata = '0; act = 1'b0; bcnt = 0; lat = 0;
    a0 = '0; wd0 = '0; we0 = 1'b0; port_d = 1'b0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (reset !== 1'b1) begin act = 1'b0; continue; end
      if (mem_req && !act) begin
        act = 1'b1; bcnt = 1; a0 = mem_addr; we0 = mem_we; wd0 = mem_wdata;
        if (!snap_i && !snap_d) fail_now("grant_without_request");
        port_d = (snap_i && snap_d) ? (RR ? !last_d : 1'b1) : snap_d;
        chk("grant_addr", mem_addr, port_d ? d_addr : i_addr);
        chk("grant_we", mem_we, port_d ? d_we : 1'b0);
        if (port_d && d_we) chk("grant_wdata", mem_wdata, d_wdata);
        if (port_d) gnt_d = 1'b1; else gnt_i = 1'b1;
        last_d = port_d;
        lat = port_d ? lat_d : lat_i;
      end else if (mem_req && act) begin
        bcnt++;
        chk("bus_held", {mem_we, mem_addr, mem_wdata}, {we0, a0, wd0});
        if (bcnt > TMO) fail_now("mem_req_past_timeout");
      end else if (!mem_req && act) begin
        act = 1'b0;
        chk("busy_cycles", bcnt, (lat >= TMO) ? TMO : lat + 1);
      end
      if (act && (lat == bcnt - 1)) begin
        mem_ack = 1'b1;
        mem_rdata = we0 ? $urandom : mem_read(a0);
        if (we0) mem_st[int'(a0)] = wd0;
      end else if (!act && !mem_req && stray_en && ($urandom_range(0, 3) == 0)) begin
        mem_ack = 1'b1;
        mem_rdata = $urandom;
      end
    end
  end

  // Scoreboard monitor: pops an expectation for every valid pulse.
  initial begin
    exp_t e;
    bit   prev_iv, prev_dv;
    prev_iv = 1'b0; prev_dv = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (reset === 1'b1) begin
        if (i_valid) begin
          if (q_i.size() == 0) fail_now("i_valid_unexpected");
          else begin
            e = q_i.pop_front();
            chk("i_rdata", i_rdata, e.rdata);
            if (e.tmo) err_exp = 1'b1;
          end
          if (prev_iv) fail_now("i_valid_longer_than_one_cycle");
        end
        if (d_valid) begin
          if (q_d.size() == 0) fail_now("d_valid_unexpected");
          else begin
            e = q_d.pop_front();
            chk("d_rdata", d_rdata, e.rdata);
            if (e.tmo) err_exp = 1'b1;
          end
          if (prev_dv) fail_now("d_valid_longer_than_one_cycle");
        end
        chk("err", err, err_exp);
        chk("stall_f", stall_f, i_req & ~i_valid);
        chk("stall_m", stall_m, d_req & ~d_valid);
      end
      prev_iv = i_valid; prev_dv = d_valid;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n, ni, nd;
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    pend_i = 0; pend_d = 0; gnt_i = 0; gnt_d = 0; last_d = 0; err_exp = 0; stray_en = 0;
    last_i_rd = '0; last_d_rd = '0; lat_i = 0; lat_d = 0;

    // Reset held with both requesting; data wins the first grant.
    @(negedge clk);
    issue_i(32'h20, 0);
    issue_d(1'b0, 32'h140, 32'h0, 0);
    repeat (2) begin
      @(negedge clk); #1;
      chk("rst_mem_req", mem_req, 0);     chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);   chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_i_valid", i_valid, 0);     chk("rst_d_valid", d_valid, 0);
      chk("rst_i_rdata", i_rdata, 0);     chk("rst_d_rdata", d_rdata, 0);
      chk("rst_err", err, 0);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    chk("first_mem_req", mem_req, 1);
    chk("first_grant_is_data", mem_addr, 32'h140);
    fork wait_i(ni); wait_d(nd); join

    // Single fetch, ack on the second busy cycle.
    @(negedge clk); issue_i(32'h10, 1); wait_i(n);
    chk("fetch_latency", n, 3);

    // Contention: data first, fetch after the bubble.
    @(negedge clk);
    issue_d(1'b0, 32'h160, 32'h0, 0);
    issue_i(32'h30, 0);
    fork wait_d(nd); wait_i(ni); join
    chk("contention_d_latency", nd, 2);
    chk("contention_i_latency", ni, 4);

    // Store then load back.
    @(negedge clk); issue_d(1'b1, 32'h164, 32'h19, 1); wait_d(n);
    chk("store_latency", n, 3);
    @(negedge clk); issue_d(1'b0, 32'h164, 32'h0, 0); wait_d(n);

    // Watchdog expiry, then normal traffic, then ack coinciding with expiry.
    @(negedge clk); issue_i(32'h40, NEVER); wait_i(n);
    chk("timeout_latency", n, TMO + 1);
    @(negedge clk); issue_d(1'b0, 32'h168, 32'h0, 2); wait_d(n);
    chk("err_sticky", err, 1);
    @(negedge clk); issue_i(32'h44, TMO - 1); wait_i(n);
    chk("ack_at_expiry_latency", n, TMO + 1);

    // Simultaneous requests exercise the tie-break policy.
    repeat (4) begin
      @(negedge clk);
      issue_d(1'b0, 32'h100 + (32'($urandom_range(0, 63)) << 2), 32'h0, int'($urandom_range(0, 2)));
      issue_i(32'($urandom_range(0, 63)) << 2, int'($urandom_range(0, 2)));
      fork wait_d(nd); wait_i(ni); join
    end

    // Random concurrent traffic with stray acks while idle.
    stray_en = 1'b1;
    fork drive_i(30); drive_d(30); join
    stray_en = 1'b0;

    // Reset in the middle of a transaction abandons it.
    @(negedge clk); issue_i(32'h50, NEVER);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; i_req = 1'b0; pend_i = 0; gnt_i = 0;
    q_i.delete(); q_d.delete();
    err_exp = 1'b0; last_i_rd = '0; last_d_rd = '0; last_d = 1'b0;
    @(negedge clk); #1;
    chk("mid_reset_mem_req", mem_req, 0);
    chk("mid_reset_err", err, 0);
    @(negedge clk); reset = 1'b1;
    repeat (6) @(negedge clk);
    issue_d(1'b0, 32'h170, 32'h0, 0); wait_d(n);
    chk("post_reset_latency", n, 2);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
